muldiv_sequencer: RTL and testbench

//  Multi-cycle M-extension controller (MUL, MULHU, DIVU, REMU) that reuses the shared
//  32-bit ALU instead of owning an adder. Sits in EX beside the ALU.
//  - While busy it drives ALU Operation/SrcA/SrcB and consumes ALUResult.
//  - Holds the pipeline stalled until the result is ready.
//  - Radix-2: one ALU ADD (multiply) or SUB (divide) per cycle.

---
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Radix-2 MUL/MULHU/DIVU/REMU sequencer that borrows the shared EX-stage ALU for its add/subtract.
// Latency 33 cycles from accept to done (1 for divide-by-zero); busy_o stalls the pipe, flush aborts.
module muldiv_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [1:0]               funct_i,
  input  logic [DATA_WIDTH-1:0]    op_a_i,
  input  logic [DATA_WIDTH-1:0]    op_b_i,
  input  logic                     flush_i,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic [OPCODE_LENGTH-1:0] alu_op_o,
  output logic [DATA_WIDTH-1:0]    alu_a_o,
  output logic [DATA_WIDTH-1:0]    alu_b_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [DATA_WIDTH-1:0]    result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(1);
  localparam logic [CNT_WIDTH-1:0]     LAST    = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic [1:0]            funct_q, funct_n;
  // hi: product high half / remainder; lo: multiplier / quotient; opnd: multiplicand / divisor
  logic [DATA_WIDTH-1:0] hi, hi_n;
  logic [DATA_WIDTH-1:0] lo, lo_n;
  logic [DATA_WIDTH-1:0] opnd, opnd_n;
  logic [DATA_WIDTH-1:0] result_q, result_n;
  logic [DATA_WIDTH-1:0] rs;
  logic                  carry;
  logic                  ge;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      funct_q  <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      result_q <= '0;
    end else begin
      cnt      <= cnt_n;
      funct_q  <= funct_n;
      hi       <= hi_n;
      lo       <= lo_n;
      opnd     <= opnd_n;
      result_q <= result_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    funct_n  = funct_q;
    hi_n     = hi;
    lo_n     = lo;
    opnd_n   = opnd;
    result_n = result_q;
    alu_op_o = '0;
    alu_a_o  = '0;
    alu_b_o  = '0;
    carry    = 1'b0;
    ge       = 1'b0;
    rs       = {hi[DATA_WIDTH-2:0], lo[DATA_WIDTH-1]};

    unique case (state)
      IDLE: begin
        if (start_i) begin
          funct_n = funct_i;
          cnt_n   = '0;
          hi_n    = '0;
          if (funct_i[1]) begin
            lo_n   = op_a_i;
            opnd_n = op_b_i;
            // Divide-by-zero resolves immediately without touching the ALU
            if (op_b_i == '0) begin
              state_n  = DONE;
              result_n = funct_i[0] ? op_a_i : '1;
            end else begin
              state_n = CALC;
            end
          end else begin
            lo_n    = op_b_i;
            opnd_n  = op_a_i;
            state_n = CALC;
          end
        end
      end

      CALC: begin
        cnt_n = cnt + 1'b1;
        if (funct_q[1]) begin
          alu_op_o = ALU_SUB;
          alu_a_o  = rs;
          alu_b_o  = opnd;
          ge       = hi[DATA_WIDTH-1] | (rs >= opnd);
          hi_n     = ge ? alu_result : rs;
          lo_n     = {lo[DATA_WIDTH-2:0], ge};
        end else begin
          alu_op_o = ALU_ADD;
          alu_a_o  = hi;
          alu_b_o  = lo[0] ? opnd : '0;
          carry    = (alu_result < hi);
          hi_n     = {carry, alu_result[DATA_WIDTH-1:1]};
          lo_n     = {alu_result[0], lo[DATA_WIDTH-1:1]};
        end
        if (cnt == LAST) begin
          state_n  = DONE;
          result_n = funct_q[0] ? hi_n : lo_n;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Flush freezes all datapath state and beats any start in the same cycle
    if (flush_i) begin
      state_n  = IDLE;
      cnt_n    = cnt;
      funct_n  = funct_q;
      hi_n     = hi;
      lo_n     = lo;
      opnd_n   = opnd;
      result_n = result_q;
    end
  end

  assign busy_o   = (state == CALC);
  assign done_o   = (state == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random model vectors and abort sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  funct_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic [31:0] alu_result;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .funct_i    (funct_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .flush_i    (flush_i),
    .alu_result (alu_result),
    .alu_op_o   (alu_op_o),
    .alu_a_o    (alu_a_o),
    .alu_b_o    (alu_b_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  // Shared ALU stand-in
  assign alu_result = (alu_op_o == 4'b0010) ? alu_a_o + alu_b_o :
                      (alu_op_o == 4'b0001) ? alu_a_o - alu_b_o : 32'h0;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    case (f)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // inj=1 re-asserts start (9*9, DIVU funct) at CALC cycle 10
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit inj);
    int cyc;
    int busy_cnt;
    bit got;
    logic [31:0] e;
    @(negedge clk);
    start_i = 1'b1; funct_i = f; op_a_i = a; op_b_i = b;
    sb.push_back(exp);
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1; busy_cnt = 0; got = 0;
    while (!got && cyc < 100) begin
      if (done_o) begin
        got = 1;
        chk("latency", 32'(cyc), 32'(lat));
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result_o, e);
        end
      end else begin
        if (busy_o) busy_cnt++;
        if (cyc == 1 && busy_o) chk("alu_op", {28'h0, alu_op_o}, f[1] ? 32'd1 : 32'd2);
        if (inj && cyc == 10) begin
          start_i = 1'b1; funct_i = 2'd2; op_a_i = 32'd9; op_b_i = 32'd9;
        end else begin
          start_i = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start_i = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(lat - 1));
    @(negedge clk);
    chk("done_pulse", {31'h0, done_o}, 32'd0);
  endtask

  // mode 0: flush, mode 1: reset, asserted at CALC cycle 'at'
  task automatic abort_op(input bit mode, input int at, input logic [31:0] prev);
    int ndone;
    @(negedge clk);
    start_i = 1'b1; funct_i = 2'd0; op_a_i = 32'd2; op_b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c < at; c++) @(negedge clk);
    chk("busy_before_abort", {31'h0, busy_o}, 32'd1);
    if (mode) reset = 1'b1; else flush_i = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush_i = 1'b0;
    chk("abort_busy", {31'h0, busy_o}, 32'd0);
    chk("abort_done", {31'h0, done_o}, 32'd0);
    chk("abort_result", result_o, mode ? 32'h0 : prev);
    if (mode) begin
      chk("reset_alu_op", {28'h0, alu_op_o}, 32'd0);
      chk("reset_alu_a", alu_a_o, 32'd0);
      chk("reset_alu_b", alu_b_o, 32'd0);
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd0, 32'd7,          32'd6,          32'd42,         33};
    vecs[1] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33};
    vecs[2] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
    vecs[3] = '{2'd2, 32'd100,        32'd7,          32'd14,         33};
    vecs[4] = '{2'd3, 32'd100,        32'd7,          32'd2,          33};
    vecs[5] = '{2'd2, 32'h8000_0000,  32'd1,          32'h8000_0000,  33};
    vecs[6] = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7] = '{2'd3, 32'd5,          32'd0,          32'd5,          1};

    reset = 1'b1; start_i = 1'b0; funct_i = 2'd0; op_a_i = '0; op_b_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", result_o, 32'd0);
    chk("rst_done", {31'h0, done_o}, 32'd0);
    chk("rst_busy", {31'h0, busy_o}, 32'd0);
    chk("rst_alu_op", {28'h0, alu_op_o}, 32'd0);
    chk("rst_alu_a", alu_a_o, 32'd0);
    chk("rst_alu_b", alu_b_o, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  f;
      logic [31:0] a, b;
      f = 2'($urandom_range(0, 3));
      a = $urandom();
      b = (i == 3) ? 32'h0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom());
      run_op(f, a, b, model(f, a, b), (f[1] && b == 0) ? 1 : 33, 1'b0);
    end

    run_op(2'd0, 32'd3, 32'd3, 32'd9, 33, 1'b1);
    run_op(2'd0, 32'd9, 32'd9, 32'd81, 33, 1'b0);

    abort_op(1'b0, 5, 32'd81);
    abort_op(1'b1, 20, 32'd81);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
